dds_channel_scheduler: RTL and testbench

Time-multiplexes the single shared phase-to-amplitude converter across NUM_CH independent DDS channels. Each channel owns a frequency tuning word, an enable bit and a phase accumulator. On every sample tick the block scans the channels in order, presents each accumulator to the converter, captures the returned amplitude as a tagged sample, and advances the accumulator. A valid/ready config port programs the channels between frames.

---
 rtl/dds_pkg.sv | 16 +
 rtl/dds_tick_gen.sv | 30 +++
 rtl/dds_channel_scheduler.sv | 118 +++++++++++
 tb/tb_dds_channel_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared widths, mid-scale constant and scheduler state encoding for the DDS block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_pkg;

  localparam int PHASE_W = 10;
  localparam int AMP_W   = 10;
  localparam int AMP_MID = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/dds_tick_gen.sv
// Free-running frame counter 0..TICK_DIV-1 with a terminal-count pulse.
// Latency: tick is a combinational decode of the counter register.
// Backpressure: none, the counter never stalls.
module dds_tick_gen #(
  parameter int TICK_DIV = 16,
  parameter int CNT_W    = $clog2(TICK_DIV)
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;

  // Count up and wrap explicitly so non-power-of-two dividers work too.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign tick = (tick_cnt == LAST);

endmodule

// File: rtl/dds_channel_scheduler.sv
// Time-multiplexes one external phase-to-amplitude converter across NUM_CH DDS channels.
// Latency: sample for scan slot k is registered and strobed one cycle later.
// Backpressure: cfg_ready drops for the NUM_CH+1 busy cycles of each frame; samples are never stalled.
module dds_channel_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PHASE_W  = dds_pkg::PHASE_W,
  parameter int AMP_W    = dds_pkg::AMP_W,
  parameter int TICK_DIV = 16,
  parameter int CH_W     = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_ftw,
  input  logic               cfg_en,
  input  logic               cfg_phase_rst,
  output logic               conv_reset,
  output logic [PHASE_W-1:0] conv_phase,
  input  logic [AMP_W-1:0]   conv_amp,
  output logic               smp_valid,
  output logic [CH_W-1:0]    smp_ch,
  output logic [AMP_W-1:0]   smp_amp,
  output logic               frame_done,
  output logic               busy
);

  import dds_pkg::*;

  sched_state_t       state;
  logic [CH_W-1:0]    scan_ch;
  logic [PHASE_W-1:0] acc [NUM_CH];
  logic [PHASE_W-1:0] ftw [NUM_CH];
  logic [NUM_CH-1:0]  en;
  logic               tick;
  logic               cfg_fire;
  logic               last_ch;
  logic               scan_hit;

  dds_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Config is only taken between frames, so it never races the accumulator update.
  assign cfg_fire = cfg_valid && (state == ST_IDLE);
  assign last_ch  = (scan_ch == CH_W'(NUM_CH - 1));
  assign scan_hit = (state == ST_SCAN) && en[scan_ch];

  // Frame sequencer plus the registered sample stage fed by the converter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      scan_ch   <= '0;
      smp_valid <= 1'b0;
      smp_ch    <= '0;
      smp_amp   <= AMP_W'(AMP_MID);
    end else begin
      smp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            state   <= ST_SCAN;
            scan_ch <= '0;
          end
        end
        ST_SCAN: begin
          if (en[scan_ch]) begin
            smp_valid <= 1'b1;
            smp_ch    <= scan_ch;
            smp_amp   <= conv_amp;
          end
          scan_ch <= scan_ch + CH_W'(1);
          if (last_ch) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Per-channel tuning state: written by config in IDLE, advanced by the scan in SCAN.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        ftw[i] <= '0;
      end
      en <= '0;
    end else if (cfg_fire) begin
      ftw[cfg_ch] <= cfg_ftw;
      en[cfg_ch]  <= cfg_en;
      if (cfg_phase_rst) begin
        acc[cfg_ch] <= '0;
      end
    end else if (scan_hit) begin
      // Natural wrap of the PHASE_W-bit sum is the intended modulo behaviour.
      acc[scan_ch] <= acc[scan_ch] + ftw[scan_ch];
    end
  end

  assign conv_phase = (state == ST_SCAN) ? acc[scan_ch] : '0;
  assign frame_done = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign cfg_ready  = (state == ST_IDLE);
  assign conv_reset = reset;

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Scoreboard bench for dds_channel_scheduler with a frame-level reference model.
// Latency: expected samples are queued at frame start and popped as smp_valid appears.
// Backpressure: config writes hold cfg_valid until cfg_ready is seen.
module tb_dds_channel_scheduler;

  localparam int NUM_CH   = 4;
  localparam int PHASE_W  = 10;
  localparam int AMP_W    = 10;
  localparam int TICK_DIV = 16;
  localparam int CH_W     = 2;
  localparam int PMOD     = 1 << PHASE_W;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [PHASE_W-1:0] cfg_ftw = '0;
  logic               cfg_en = 1'b0;
  logic               cfg_phase_rst = 1'b0;
  logic               conv_reset;
  logic [PHASE_W-1:0] conv_phase;
  logic [AMP_W-1:0]   conv_amp;
  logic               smp_valid;
  logic [CH_W-1:0]    smp_ch;
  logic [AMP_W-1:0]   smp_amp;
  logic               frame_done;
  logic               busy;

  always #5 clk = ~clk;

  dds_channel_scheduler #(
    .NUM_CH   (NUM_CH),
    .PHASE_W  (PHASE_W),
    .AMP_W    (AMP_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_ch        (cfg_ch),
    .cfg_ftw       (cfg_ftw),
    .cfg_en        (cfg_en),
    .cfg_phase_rst (cfg_phase_rst),
    .conv_reset    (conv_reset),
    .conv_phase    (conv_phase),
    .conv_amp      (conv_amp),
    .smp_valid     (smp_valid),
    .smp_ch        (smp_ch),
    .smp_amp       (smp_amp),
    .frame_done    (frame_done),
    .busy          (busy)
  );

  // Stand-in converter: parabolic sine approximation, 100 mid-scale, 0..200 swing.
  function automatic int conv_fn(input int p);
    int d;
    if (p < 512) begin
      return 100 + (p * (512 - p) * 100) / 65536;
    end
    d = p - 512;
    return 100 - (d * (512 - d) * 100) / 65536;
  endfunction

  always_comb conv_amp = AMP_W'(conv_fn(int'(conv_phase)));

  typedef struct {
    int ch;
    int amp;
  } smp_t;

  smp_t exp_q[$];
  smp_t log_q[$];
  int   checks = 0;
  int   errors = 0;

  int   m_acc [NUM_CH];
  int   m_ftw [NUM_CH];
  bit   m_en  [NUM_CH];
  int   tc = 0;
  int   busy_left = 0;
  bit   model_ok = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frame-level view of the channel table, updated at clock edges.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_acc[i] = 0;
        m_ftw[i] = 0;
        m_en[i]  = 1'b0;
      end
      tc        = 0;
      busy_left = 0;
      exp_q.delete();
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (busy_left == 0 && cfg_valid) begin
        m_ftw[cfg_ch] = int'(cfg_ftw);
        m_en[cfg_ch]  = cfg_en;
        if (cfg_phase_rst) m_acc[cfg_ch] = 0;
      end
      if (busy_left == 0 && tc == TICK_DIV - 1) begin
        for (int k = 0; k < NUM_CH; k++) begin
          if (m_en[k]) begin
            smp_t e;
            e.ch  = k;
            e.amp = conv_fn(m_acc[k]);
            exp_q.push_back(e);
            m_acc[k] = (m_acc[k] + m_ftw[k]) % PMOD;
          end
        end
        busy_left = NUM_CH + 1;
      end else if (busy_left > 0) begin
        busy_left--;
      end
      tc = (tc + 1) % TICK_DIV;
    end
  end

  // Monitor: per-cycle handshake/status checks and sample scoreboard.
  initial forever begin
    @(negedge clk);
    if (model_ok) begin
      chk("busy", int'(busy), int'(busy_left > 0));
      chk("cfg_ready", int'(cfg_ready), int'(busy_left == 0));
      chk("frame_done", int'(frame_done), int'(busy_left == 1));
      chk("conv_reset", int'(conv_reset), int'(reset));
      if (busy_left == 0) chk("conv_phase_idle", int'(conv_phase), 0);
      if (smp_valid) begin
        smp_t a;
        a.ch  = int'(smp_ch);
        a.amp = int'(smp_amp);
        log_q.push_back(a);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got ch %0d amp %0d, expected no sample", a.ch, a.amp);
        end else begin
          smp_t e;
          e = exp_q.pop_front();
          chk("smp_ch", a.ch, e.ch);
          chk("smp_amp", a.amp, e.amp);
        end
      end
    end
  end

  task automatic cfg_write(input int ch, input int ftw, input bit en, input bit prst,
                           output int lowcnt);
    bit done;
    done          = 1'b0;
    lowcnt        = 0;
    cfg_valid     = 1'b1;
    cfg_ch        = CH_W'(ch);
    cfg_ftw       = PHASE_W'(ftw);
    cfg_en        = en;
    cfg_phase_rst = prst;
    for (int i = 0; i < 4 * TICK_DIV && !done; i++) begin
      if (cfg_ready) begin
        done = 1'b1;
      end else begin
        lowcnt++;
      end
      @(negedge clk);
    end
    cfg_valid     = 1'b0;
    cfg_phase_rst = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL cfg_timeout: cfg_ready low %0d cycles, required a handshake", lowcnt);
    end
  endtask

  task automatic wait_frames(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < (n + 4) * TICK_DIV && seen < n; i++) begin
      @(negedge clk);
      if (frame_done) seen++;
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: saw %0d frames, required %0d", seen, n);
    end
    #1;
  endtask

  // Returns at the negedge of the first SCAN cycle of a new frame.
  task automatic wait_scan_entry();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else @(negedge clk);
    end
    ok = 1'b0;
    for (int i = 0; i < 4 * TICK_DIV && !ok; i++) begin
      @(negedge clk);
      if (busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: busy stayed %0d, required a SCAN entry", int'(busy));
    end
  endtask

  function automatic int first_amp(input int ch);
    foreach (log_q[i]) begin
      if (log_q[i].ch == ch) return log_q[i].amp;
    end
    return -1;
  endfunction

  initial begin
    int lc;
    int ch0_tab [5];
    int vcnt;
    int vch;
    int done_off;
    ch0_tab = '{100, 200, 100, 0, 100};

    // Reset and quiet idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_smp_amp", int'(smp_amp), 100);
    chk("rst_smp_valid", int'(smp_valid), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_conv_phase", int'(conv_phase), 0);
    chk("rst_busy", int'(busy), 0);

    // ch0 alone, quarter-turn steps
    cfg_write(0, 256, 1'b1, 1'b0, lc);
    log_q.delete();
    wait_frames(5);
    chk("ch0_count", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      chk("ch0_tag", log_q[i].ch, 0);
      chk("ch0_amp", log_q[i].amp, ch0_tab[i]);
    end

    // ch1 alone, wrapping accumulator
    cfg_write(0, 256, 1'b0, 1'b0, lc);
    cfg_write(1, 1000, 1'b1, 1'b0, lc);
    log_q.delete();
    wait_frames(3);
    chk("ch1_count", log_q.size(), 3);
    if (log_q.size() >= 3) begin
      chk("ch1_amp_p0", log_q[0].amp, conv_fn(0));
      chk("ch1_amp_p1000", log_q[1].amp, conv_fn(1000));
      chk("ch1_amp_p976", log_q[2].amp, conv_fn(976));
      chk("ch1_tag", log_q[2].ch, 1);
    end

    // ch2 alone: one strobe per frame, frame_done in the last busy cycle
    cfg_write(1, 1000, 1'b0, 1'b0, lc);
    cfg_write(2, 100, 1'b1, 1'b0, lc);
    wait_scan_entry();
    vcnt     = 0;
    vch      = -1;
    done_off = -1;
    for (int off = 0; off <= NUM_CH + 1; off++) begin
      if (smp_valid) begin
        vcnt++;
        vch = int'(smp_ch);
      end
      if (frame_done) done_off = off;
      @(negedge clk);
    end
    chk("ch2_strobes", vcnt, 1);
    chk("ch2_tag", vch, 2);
    chk("ch2_done_offset", done_off, NUM_CH);

    // Config held from the first SCAN cycle stays pending until IDLE
    wait_scan_entry();
    cfg_write(3, 300, 1'b1, 1'b1, lc);
    chk("cfg_hold_low_cycles", lc, NUM_CH + 1);
    log_q.delete();
    wait_frames(2);
    chk("ch3_restart_amp", first_amp(3), 100);

    // Randomized config traffic against the model
    for (int it = 0; it < 40; it++) begin
      cfg_write(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, PMOD - 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), lc);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_write(c, int'($urandom_range(1, PMOD - 1)), 1'b1, 1'b0, lc);
    end
    wait_frames(2);

    // Reset during the ch1 scan slot
    wait_scan_entry();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_smp_valid", int'(smp_valid), 0);
    chk("midrst_smp_amp", int'(smp_amp), 100);
    chk("midrst_busy", int'(busy), 0);
    reset = 1'b0;
    log_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_write(c, int'($urandom_range(1, PMOD - 1)), 1'b1, 1'b0, lc);
    end
    wait_frames(2);
    for (int c = 0; c < NUM_CH; c++) begin
      chk("post_rst_acc_zero", first_amp(c), 100);
    end

    repeat (2 * TICK_DIV) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
